// File: rtl/mux_n_reg.sv
// rtl/mux_n_reg.sv - registered N-channel valid/ready multiplexer with one-entry output register.
// Optional round-robin auto-select mode is built when MUX_RR_EN is defined.
module mux_n_reg #(
    parameter int   N  = 4,
    parameter int   W  = 8,
    localparam int  SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
`ifdef MUX_RR_EN
    input  logic           mode,
`endif
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_chan;
    logic          r_out_valid;

    logic          w_load_ok;
    logic          w_grant_vld;
    logic [SW-1:0] w_grant;
    logic          w_xfer;

`ifdef MUX_RR_EN
    logic [SW-1:0] r_ptr;
`endif

    assign w_load_ok = !r_out_valid || out_ready;

    always_comb begin
        int            v_idx;
        logic [SW-1:0] v_k;
        w_grant_vld = 1'b0;
        w_grant     = '0;
        v_idx       = 0;
        v_k         = '0;
`ifdef MUX_RR_EN
        if (mode) begin
            // Scan downward so the last hit is the first valid channel at or after ptr.
            for (int i = N - 1; i >= 0; i--) begin
                v_idx = int'(r_ptr) + i;
                if (v_idx >= N) v_idx = v_idx - N;
                v_k = SW'(v_idx);
                if (in_valid[v_k]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = v_k;
                end
            end
        end else
`endif
        begin
            // Out-of-range selects never match any k, so they are never granted.
            for (int k = 0; k < N; k++) begin
                if (sel == SW'(k) && in_valid[k]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = SW'(k);
                end
            end
        end
    end

    assign w_xfer   = !rst && w_grant_vld && w_load_ok;
    assign in_ready = w_xfer ? (N'(1) << w_grant) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[int'(w_grant)*W +: W];
            r_out_chan  <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef MUX_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer && mode) begin
            r_ptr <= (w_grant == SW'(N - 1)) ? '0 : w_grant + 1'b1;
        end
    end
`endif

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_n_reg.sv
// tb/tb_mux_n_reg.sv - self-checking bench for mux_n_reg (N=4 and N=3 instances).
module tb_mux_n_reg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic        mode3;
    logic [7:0]  out_data3;
    logic [1:0]  out_chan3;
    logic        out_valid3;
    logic        out_ready3;

    int n_vec = 0;
    int n_err = 0;

    mux_n_reg #(.N(4), .W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel),
`ifdef MUX_RR_EN
        .mode(mode),
`endif
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_n_reg #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .sel(sel3),
`ifdef MUX_RR_EN
        .mode(mode3),
`endif
        .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'b1111; sel = 2'd2; out_ready = 1'b1;
        in_data = 32'h4433_2211; mode = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if (in_ready !== 4'b0000) begin
                n_err++; $display("FAIL reset_in_ready got=%b want=0000", in_ready);
            end
            tick();
        end
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b d=%h c=%0d want v=0 d=00 c=0",
                     out_valid, out_data, out_chan);
        end
    endtask

    task automatic test_explicit();
        rst = 1'b0; in_data = {8'h44, 8'h33, 8'h22, 8'h11}; in_valid = 4'b1111;
        sel = 2'd2; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if (in_ready !== 4'b0100) begin
                n_err++; $display("FAIL explicit_in_ready got=%b want=0100", in_ready);
            end
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 8'h33 || out_chan !== 2'd2) begin
                n_err++;
                $display("FAIL explicit_out got v=%b d=%h c=%0d want v=1 d=33 c=2",
                         out_valid, out_data, out_chan);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_data[23:16] = 8'hAA;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if (in_ready !== 4'b0000) begin
                n_err++; $display("FAIL stall_in_ready got=%b want=0000", in_ready);
            end
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 8'h33 || out_chan !== 2'd2) begin
                n_err++;
                $display("FAIL stall_hold got v=%b d=%h c=%0d want v=1 d=33 c=2",
                         out_valid, out_data, out_chan);
            end
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 4'b0100) begin
            n_err++; $display("FAIL release_in_ready got=%b want=0100", in_ready);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'hAA) begin
            n_err++; $display("FAIL release_out got v=%b d=%h want v=1 d=aa", out_valid, out_data);
        end
        // Consume with nothing granted: valid drops, data and chan hold.
        in_valid = 4'b0000;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'hAA || out_chan !== 2'd2) begin
            n_err++;
            $display("FAIL drain got v=%b d=%h c=%0d want v=0 d=aa c=2",
                     out_valid, out_data, out_chan);
        end
    endtask

`ifdef MUX_RR_EN
    task automatic test_rr();
        int exp_seq[6] = '{0, 1, 3, 0, 1, 3};
        rst = 1'b1; in_valid = 4'b1011; mode = 1'b1; out_ready = 1'b1;
        in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || int'(out_chan) != exp_seq[c]) begin
                n_err++;
                $display("FAIL rr_seq[%0d] got v=%b c=%0d want v=1 c=%0d",
                         c, out_valid, out_chan, exp_seq[c]);
            end
        end
        in_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_data !== 8'hC2) begin
                n_err++;
                $display("FAIL rr_single got v=%b c=%0d d=%h want v=1 c=2 d=c2",
                         out_valid, out_chan, out_data);
            end
        end
        in_valid = 4'b0000;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL rr_empty got v=%b want v=0", out_valid);
        end
        mode = 1'b0;
    endtask
`endif

    task automatic test_n3_oob();
        in_data3 = {8'h77, 8'h66, 8'h55}; in_valid3 = 3'b111; sel3 = 2'd3;
        out_ready3 = 1'b1; mode3 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if (in_ready3 !== 3'b000) begin
                n_err++; $display("FAIL n3_oob_in_ready got=%b want=000", in_ready3);
            end
            tick();
            n_vec++;
            if (out_valid3 !== 1'b0) begin
                n_err++; $display("FAIL n3_oob_valid got=%b want=0", out_valid3);
            end
        end
        sel3 = 2'd1;
        #1;
        n_vec++;
        if (in_ready3 !== 3'b010) begin
            n_err++; $display("FAIL n3_sel1_in_ready got=%b want=010", in_ready3);
        end
        tick();
        n_vec++;
        if (out_valid3 !== 1'b1 || out_chan3 !== 2'd1 || out_data3 !== 8'h66) begin
            n_err++;
            $display("FAIL n3_sel1_out got v=%b c=%0d d=%h want v=1 c=1 d=66",
                     out_valid3, out_chan3, out_data3);
        end
        in_valid3 = 3'b000;
    endtask

    task automatic test_mid_reset();
        rst = 1'b0; mode = 1'b0; in_data = 32'h1234_5678; in_valid = 4'b0010;
        sel = 2'd1; out_ready = 1'b0;
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'h56) begin
            n_err++; $display("FAIL midrst_load got v=%b d=%h want v=1 d=56", out_valid, out_data);
        end
        rst = 1'b1; out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 4'b0000) begin
            n_err++; $display("FAIL midrst_in_ready got=%b want=0000", in_ready);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
            n_err++;
            $display("FAIL midrst_out got v=%b d=%h c=%0d want v=0 d=00 c=0",
                     out_valid, out_data, out_chan);
        end
        rst = 1'b0;
    endtask

    // Reference model: state of the output register and RR pointer, updated from the rules.
    task automatic test_random();
        bit       m_valid = 0;
        int       m_data  = 0;
        int       m_chan  = 0;
        int       m_ptr   = 0;
        int       g;
        bit       g_ok;
        bit       md;
        logic [3:0] exp_rdy;
        rst = 1'b1; in_valid = '0; out_ready = 1'b0;
        tick();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 31) == 0);
            in_data   = $urandom;
            in_valid  = 4'($urandom);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            mode      = 1'($urandom);
`ifdef MUX_RR_EN
            md = mode;
`else
            md = 1'b0;
`endif
            g_ok = 0; g = 0;
            if (!rst) begin
                if (md) begin
                    for (int d = 0; d < 4 && !g_ok; d++) begin
                        if (in_valid[(m_ptr + d) % 4]) begin g_ok = 1; g = (m_ptr + d) % 4; end
                    end
                end else if (in_valid[sel]) begin
                    g_ok = 1; g = int'(sel);
                end
            end
            if (!(g_ok && (!m_valid || out_ready))) g_ok = 0;
            exp_rdy = g_ok ? 4'(1 << g) : 4'b0000;
            #1;
            n_vec++;
            if (in_ready !== exp_rdy) begin
                n_err++; $display("FAIL rand_in_ready[%0d] got=%b want=%b", c, in_ready, exp_rdy);
            end
            if (rst) begin
                m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
            end else if (g_ok) begin
                m_valid = 1; m_data = int'(in_data[g*8 +: 8]); m_chan = g;
                if (md) m_ptr = (g + 1) % 4;
            end else if (out_ready) begin
                m_valid = 0;
            end
            tick();
            n_vec++;
            if (out_valid !== m_valid || int'(out_data) != m_data || int'(out_chan) != m_chan) begin
                n_err++;
                $display("FAIL rand_out[%0d] got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         c, out_valid, out_data, out_chan, m_valid, m_data[7:0], m_chan);
            end
        end
        rst = 1'b0; mode = 1'b0;
    endtask

    initial begin
        in_data3 = '0; in_valid3 = '0; sel3 = '0; mode3 = 1'b0; out_ready3 = 1'b1;
        test_reset();
        test_explicit();
        test_backpressure();
`ifdef MUX_RR_EN
        test_rr();
`endif
        test_n3_oob();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
